// File: rtl/mul32_pkg.sv
// ---------------------------------------------------------------------------
// mul32_pkg
//   Shared types and constants for the sequential 32x32 multiplier.
//   - state_t : sequencer states (IDLE, M0..M3, optional WB, DONE)
//   - shift_t : weight of a 32-bit partial product inside the 64-bit result
//   - place_partial() : zero-extends a partial product and moves it to its
//                       weight inside the 64-bit accumulator
// ---------------------------------------------------------------------------
package mul32_pkg;

  localparam int HALF_W = 16;
  localparam int OP_W   = 32;
  localparam int PROD_W = 64;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    M0   = 3'd1,
    M1   = 3'd2,
    M2   = 3'd3,
    M3   = 3'd4,
    WB   = 3'd5,
    DONE = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    SH_0  = 2'd0,
    SH_16 = 2'd1,
    SH_32 = 2'd2
  } shift_t;

  // Zero-extend a 32-bit partial product to 64 bits and shift it to its
  // weight. Bits pushed past bit 63 cannot carry information because the
  // largest partial at weight 32 still fits in the upper half.
  function automatic logic [PROD_W-1:0] place_partial(
    input logic [OP_W-1:0] part,
    input shift_t          sh
  );
    logic [PROD_W-1:0] ext;
    ext = {{(PROD_W-OP_W){1'b0}}, part};
    case (sh)
      SH_16:   return ext << HALF_W;
      SH_32:   return ext << OP_W;
      default: return ext;
    endcase
  endfunction

endpackage

// File: rtl/mul16.sv
// ---------------------------------------------------------------------------
// mul16
//   Existing 16x16 -> 32-bit unsigned combinational multiplier.
//   Ports:
//     a  in  16  multiplicand
//     b  in  16  multiplier
//     p  out 32  a*b (full width, no truncation possible)
// ---------------------------------------------------------------------------
module mul16
  import mul32_pkg::*;
(
  input  logic [HALF_W-1:0] a,
  input  logic [HALF_W-1:0] b,
  output logic [OP_W-1:0]   p
);

  // Operands are widened first so the product is computed at full width.
  assign p = {{(OP_W-HALF_W){1'b0}}, a} * {{(OP_W-HALF_W){1'b0}}, b};

endmodule

// File: rtl/mul32_seq.sv
// ---------------------------------------------------------------------------
// mul32_seq
//   Unsigned 32x32 -> 64-bit multiplier built by running one 16x16 multiplier
//   (mul16) over four partial products and summing them into a 64-bit
//   accumulator.
//
//   Parameters:
//     PIPE_MUL  0: partial product added in the same state it is formed
//               1: partial product registered first, added one state later
//                  (adds the WB state and one cycle of latency)
//
//   Ports:
//     clk        in   1   rising-edge clock
//     rst_n      in   1   asynchronous active-low reset
//     in_valid   in   1   operand pair valid
//     in_ready   out  1   block can accept operands
//     a, b       in   32  unsigned operands
//     out_valid  out  1   p holds a completed product
//     out_ready  in   1   sink accepts the product
//     p          out  64  product a*b
//     busy       out  1   sequencer is not in IDLE
//
//   Handshake: a transfer happens on a rising edge where valid && ready are
//   both high. A producer keeps valid and its data steady until that edge;
//   ready may depend on the other side's signals (in_ready follows out_ready
//   combinationally in DONE so a finished result and a new operand pair can
//   change hands on the same edge). out_valid and p depend only on state.
//
//   Debug visibility: the sequencer state is held in the signal `state`
//   (type state_t) for assertions and checkers bound to this module.
// ---------------------------------------------------------------------------
module mul32_seq
  import mul32_pkg::*;
#(
  parameter int PIPE_MUL = 0
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] p,
  output logic              busy
);

  localparam bit USE_WB = (PIPE_MUL != 0);

  state_t state;
  state_t state_nxt;

  logic [OP_W-1:0]   a_q;
  logic [OP_W-1:0]   b_q;
  logic [PROD_W-1:0] acc;

  logic              accept;

  // Multiplier operand selection for the current state.
  logic [HALF_W-1:0] mul_a;
  logic [HALF_W-1:0] mul_b;
  logic [OP_W-1:0]   mul_p;
  shift_t            shift_sel;
  logic              mul_active;

  // What actually reaches the accumulator (direct or registered).
  logic [OP_W-1:0]   add_part;
  shift_t            add_shift;
  logic              add_en;

  // -------------------------------------------------------------------------
  // Handshake signals
  // -------------------------------------------------------------------------
  // in_ready is forced low while reset is asserted so nothing can be taken
  // during reset, even though the state register already reads IDLE.
  assign in_ready  = rst_n && ((state == IDLE) || ((state == DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign p         = acc;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = M0;
        end
      end
      M0: state_nxt = M1;
      M1: state_nxt = M2;
      M2: state_nxt = M3;
      M3: state_nxt = USE_WB ? WB : DONE;
      WB: state_nxt = DONE;
      DONE: begin
        // Result leaves on out_ready; a waiting operand pair goes straight
        // into M0 so there is no IDLE bubble between products.
        if (out_ready) begin
          state_nxt = accept ? M0 : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Operand capture: only on accept, so later input changes are ignored.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
    end else if (accept) begin
      a_q <= a;
      b_q <= b;
    end
  end

  // -------------------------------------------------------------------------
  // Partial product selection
  //   M0: lo*lo  weight 0
  //   M1: lo*hi  weight 16
  //   M2: hi*lo  weight 16
  //   M3: hi*hi  weight 32
  // -------------------------------------------------------------------------
  always_comb begin
    mul_a      = a_q[HALF_W-1:0];
    mul_b      = b_q[HALF_W-1:0];
    shift_sel  = SH_0;
    mul_active = 1'b0;
    case (state)
      M0: begin
        mul_active = 1'b1;
      end
      M1: begin
        mul_b      = b_q[OP_W-1:HALF_W];
        shift_sel  = SH_16;
        mul_active = 1'b1;
      end
      M2: begin
        mul_a      = a_q[OP_W-1:HALF_W];
        shift_sel  = SH_16;
        mul_active = 1'b1;
      end
      M3: begin
        mul_a      = a_q[OP_W-1:HALF_W];
        mul_b      = b_q[OP_W-1:HALF_W];
        shift_sel  = SH_32;
        mul_active = 1'b1;
      end
      default: begin
      end
    endcase
  end

  mul16 u_mul16 (
    .a (mul_a),
    .b (mul_b),
    .p (mul_p)
  );

  // -------------------------------------------------------------------------
  // Optional product register. The weight and a valid flag travel with the
  // product so the accumulator adds exactly the four partials, one state
  // after they were formed (M1..WB instead of M0..M3).
  // -------------------------------------------------------------------------
  generate
    if (USE_WB) begin : g_pipe
      logic [OP_W-1:0] prod_q;
      shift_t          shift_q;
      logic            vld_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          prod_q  <= '0;
          shift_q <= SH_0;
          vld_q   <= 1'b0;
        end else begin
          prod_q  <= mul_p;
          shift_q <= shift_sel;
          vld_q   <= mul_active;
        end
      end

      assign add_part  = prod_q;
      assign add_shift = shift_q;
      assign add_en    = vld_q;
    end else begin : g_direct
      assign add_part  = mul_p;
      assign add_shift = shift_sel;
      assign add_en    = mul_active;
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Accumulator. Cleared on accept (including the back-to-back accept in
  // DONE, where it must not be added to). Accepts only happen in IDLE/DONE,
  // where add_en is always low, so clear and add never compete.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (accept) begin
      acc <= '0;
    end else if (add_en) begin
      acc <= acc + place_partial(add_part, add_shift);
    end
  end

endmodule

// File: tb/tb_mul32_seq.sv
// ---------------------------------------------------------------------------
// tb_mul32_seq
//   Bench for mul32_seq. Two instances (PIPE_MUL=0 and PIPE_MUL=1) share the
//   clock and reset; the directed and random sequences run on one instance
//   at a time while the other sits idle. A per-cycle compare process checks
//   every output of both instances against a transaction-level model:
//   each accepted pair becomes a job whose product is a*b and which must
//   appear exactly 5+PIPE_MUL cycles after acceptance and stay until taken.
// ---------------------------------------------------------------------------
module tb_mul32_seq;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUT signals (index = PIPE_MUL) ----------------
  logic        iv     [2];
  logic        ir     [2];
  logic [31:0] a_s    [2];
  logic [31:0] b_s    [2];
  logic        ov     [2];
  logic        ordy   [2];
  logic [63:0] p_s    [2];
  logic        busy_s [2];

  mul32_seq #(.PIPE_MUL(0)) dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv[0]),
    .in_ready  (ir[0]),
    .a         (a_s[0]),
    .b         (b_s[0]),
    .out_valid (ov[0]),
    .out_ready (ordy[0]),
    .p         (p_s[0]),
    .busy      (busy_s[0])
  );

  mul32_seq #(.PIPE_MUL(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv[1]),
    .in_ready  (ir[1]),
    .a         (a_s[1]),
    .b         (b_s[1]),
    .out_valid (ov[1]),
    .out_ready (ordy[1]),
    .p         (p_s[1]),
    .busy      (busy_s[1])
  );

  // ---------------- scoreboard / model state ----------------
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  logic [63:0] exp_q0[$];
  logic [63:0] exp_q1[$];
  bit          have_job [2];
  int          done_cyc [2];
  int          n_hs     [2];

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void q_push(int k, logic [63:0] v);
    if (k == 0) exp_q0.push_back(v);
    else        exp_q1.push_back(v);
  endfunction

  function automatic logic [63:0] q_front(int k);
    if (k == 0) return (exp_q0.size() > 0) ? exp_q0[0] : 64'hx;
    else        return (exp_q1.size() > 0) ? exp_q1[0] : 64'hx;
  endfunction

  function automatic void q_pop(int k);
    if (k == 0) begin
      if (exp_q0.size() > 0) void'(exp_q0.pop_front());
    end else begin
      if (exp_q1.size() > 0) void'(exp_q1.pop_front());
    end
  endfunction

  function automatic void q_clear(int k);
    if (k == 0) exp_q0.delete();
    else        exp_q1.delete();
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h0000_FFFF;
      3:       return 32'hFFFF_0000;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- compare process (falling edge) ----------------
  always @(negedge clk) begin : compare
    bit ev;
    bit eir;
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        chk($sformatf("rst_out_valid[%0d]", k), {63'b0, ov[k]},     64'd0);
        chk($sformatf("rst_p[%0d]", k),         p_s[k],             64'd0);
        chk($sformatf("rst_busy[%0d]", k),      {63'b0, busy_s[k]}, 64'd0);
        chk($sformatf("rst_in_ready[%0d]", k),  {63'b0, ir[k]},     64'd0);
        have_job[k] = 1'b0;
        q_clear(k);
      end else begin
        ev  = have_job[k] && (cyc >= done_cyc[k]);
        eir = !have_job[k] || (ev && ordy[k]);
        chk($sformatf("busy[%0d]", k),      {63'b0, busy_s[k]}, {63'b0, have_job[k]});
        chk($sformatf("out_valid[%0d]", k), {63'b0, ov[k]},     {63'b0, ev});
        chk($sformatf("in_ready[%0d]", k),  {63'b0, ir[k]},     {63'b0, eir});
        if (ev) chk($sformatf("p[%0d]", k), p_s[k], q_front(k));
        if (ov[k] && ordy[k]) n_hs[k]++;
        if (ev && ordy[k]) begin
          q_pop(k);
          have_job[k] = 1'b0;
        end
        if (iv[k] && eir) begin
          have_job[k] = 1'b1;
          done_cyc[k] = cyc + 5 + k;
          q_push(k, {32'b0, a_s[k]} * {32'b0, b_s[k]});
        end
      end
    end
  end

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic send(input int k, input logic [31:0] av, input logic [31:0] bv);
    bit got;
    got    = 1'b0;
    iv[k]  = 1'b1;
    a_s[k] = av;
    b_s[k] = bv;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (ir[k]) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk($sformatf("send_timeout[%0d]", k), 64'd0, 64'd1);
    @(posedge clk);
    #1;
    iv[k]  = 1'b0;
    a_s[k] = $urandom;   // must be ignored after acceptance
    b_s[k] = $urandom;
  endtask

  // Waits for out_valid, checks the literal product and (if lat>0) the
  // number of cycles since the accept edge. Returns at posedge+1.
  task automatic wait_result(input int k, input string name,
                             input logic [63:0] lit, input int lat);
    bit got;
    int cnt;
    got = 1'b0;
    cnt = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      cnt++;
      if (ov[k]) begin
        got = 1'b1;
        break;
      end
    end
    chk({name, "_seen"}, {63'b0, got}, 64'd1);
    if (lat > 0) chk({name, "_latency"}, 64'(cnt), 64'(lat));
    chk(name, p_s[k], lit);
    @(posedge clk);
    #1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "simulation time limit reached");
  end

  // ---------------- main sequence ----------------
  initial begin
    int  base;
    int  sent;
    int  cycles;
    bit  acc;
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      iv[k]   = 1'b0;
      ordy[k] = 1'b0;
      a_s[k]  = '0;
      b_s[k]  = '0;
      n_hs[k] = 0;
      have_job[k] = 1'b0;
      done_cyc[k] = 0;
    end
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int k = 0; k < 2; k++) begin
      ordy[k] = 1'b1;

      // Four partials with distinct weights.
      send(k, 32'h0001_0002, 32'h0003_0004);
      wait_result(k, $sformatf("basic[%0d]", k), 64'h0000_0003_000A_0008, 5 + k);

      // Maximum carry propagation.
      send(k, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_result(k, $sformatf("max[%0d]", k), 64'hFFFF_FFFE_0000_0001, 5 + k);

      // Accumulator must clear between operations.
      send(k, 32'h0001_0000, 32'h0001_0000);
      wait_result(k, $sformatf("bit32[%0d]", k), 64'h0000_0001_0000_0000, 5 + k);
      send(k, 32'h0000_0000, 32'hFFFF_FFFF);
      wait_result(k, $sformatf("zero[%0d]", k), 64'd0, 5 + k);

      // Sink stall for 10 cycles, then back-to-back accept.
      ordy[k] = 1'b0;
      send(k, 32'd5, 32'd9);
      for (int n = 0; n < 20; n++) begin
        @(negedge clk);
        if (ov[k]) break;
      end
      for (int n = 0; n < 10; n++) begin
        chk($sformatf("stall_valid[%0d]", k),    {63'b0, ov[k]}, 64'd1);
        chk($sformatf("stall_p[%0d]", k),        p_s[k],         64'd45);
        chk($sformatf("stall_in_ready[%0d]", k), {63'b0, ir[k]}, 64'd0);
        @(negedge clk);
      end
      @(posedge clk);
      #1;
      ordy[k] = 1'b1;
      iv[k]   = 1'b1;
      a_s[k]  = 32'd1000;
      b_s[k]  = 32'd3000;
      @(negedge clk);
      chk($sformatf("b2b_in_ready[%0d]", k), {63'b0, ir[k]}, 64'd1);
      chk($sformatf("b2b_old_p[%0d]", k),    p_s[k],         64'd45);
      @(posedge clk);
      #1;
      iv[k] = 1'b0;
      chk($sformatf("b2b_busy[%0d]", k), {63'b0, busy_s[k]}, 64'd1);
      wait_result(k, $sformatf("b2b[%0d]", k), 64'd3000000, 5 + k);

      // Asynchronous reset in the middle of M2.
      send(k, 32'd100, 32'd200);     // now in M0
      @(posedge clk);
      #1;                            // M1
      @(posedge clk);
      #1;                            // M2
      #2;
      chk($sformatf("pre_rst_busy[%0d]", k), {63'b0, busy_s[k]}, 64'd1);
      rst_n = 1'b0;
      #1;
      chk($sformatf("async_out_valid[%0d]", k), {63'b0, ov[k]},     64'd0);
      chk($sformatf("async_p[%0d]", k),         p_s[k],             64'd0);
      chk($sformatf("async_busy[%0d]", k),      {63'b0, busy_s[k]}, 64'd0);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      send(k, 32'd7, 32'd6);
      wait_result(k, $sformatf("after_rst[%0d]", k), 64'd42, 5 + k);

      // Random operands with random in_valid / out_ready throttling.
      base   = n_hs[k];
      sent   = 0;
      cycles = 0;
      while (cycles < 30000 && !(sent == 1000 && !iv[k] && !have_job[k])) begin
        @(negedge clk);
        acc = iv[k] && ir[k];
        @(posedge clk);
        #1;
        cycles++;
        if (acc) iv[k] = 1'b0;
        ordy[k] = ($urandom_range(0, 3) != 0);
        if (!iv[k] && sent < 1000 && $urandom_range(0, 3) != 0) begin
          iv[k]  = 1'b1;
          a_s[k] = pick_operand();
          b_s[k] = pick_operand();
          sent++;
        end else if (!iv[k]) begin
          a_s[k] = $urandom;
          b_s[k] = $urandom;
        end
      end
      chk($sformatf("rand_complete[%0d]", k),
          {63'b0, (sent == 1000 && !iv[k] && !have_job[k])}, 64'd1);
      chk($sformatf("rand_count[%0d]", k), 64'(n_hs[k] - base), 64'd1000);
      iv[k]   = 1'b0;
      ordy[k] = 1'b1;
      @(posedge clk);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
